// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared state encoding and default widths for the product accumulator
// Purpose: common definitions used by product_accumulator and its benches.
// Contents: state_t (ST_ACCUM / ST_DONE), PROD_W (multiplier product width), ACC_W_DEF.
package product_accumulator_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   localparam int PROD_W    = 4;
   localparam int ACC_W_DEF = 8;

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - combinational accumulator adder with optional saturation
// Purpose: sum = a + zext(b), either clamped to all-ones or wrapped on carry-out.
// Ports:
//   a    in  ACC_W   running sum
//   b    in  DATA_W  unsigned addend
//   sum  out ACC_W   next running sum
//   ovf  out 1       carry out of bit ACC_W-1 occurred
module sat_adder #(
   parameter int ACC_W    = 8,
   parameter int DATA_W   = 4,
   parameter int SATURATE = 1
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] full;

   // One extra bit so the carry is observable before truncation.
   assign full = {1'b0, a} + {{(ACC_W - DATA_W + 1){1'b0}}, b};
   assign ovf  = full[ACC_W];

   always_comb begin
      sum = full[ACC_W-1:0];
      if ((SATURATE != 0) && full[ACC_W]) begin
         sum = {ACC_W{1'b1}};
      end
   end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums TERMS product beats into one registered result
// Purpose: MAC tail for the 2x2 multiplier product stream; valid/ready in and out.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               synchronous abort of partial or held result
//   prod_data/valid     product beat in;  prod_ready out (combinational)
//   acc_data/valid/ovf  registered result out; acc_ready in
//   term_cnt            beats accepted into the current sum
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int DATA_W   = PROD_W,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int TERMS    = 4,
   parameter int SATURATE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic [DATA_W-1:0]          prod_data,
   input  logic                       prod_valid,
   output logic                       prod_ready,
   output logic [ACC_W-1:0]           acc_data,
   output logic                       acc_valid,
   input  logic                       acc_ready,
   output logic                       acc_ovf,
   output logic [$clog2(TERMS+1)-1:0] term_cnt
);

   localparam int             CW   = $clog2(TERMS + 1);
   localparam logic [CW-1:0]  LAST = CW'(TERMS - 1);

   state_t           state;
   logic [ACC_W-1:0] sum_q;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;
   logic             beat;

   // Held low during clear so a beat is never half-consumed.
   assign prod_ready = (state == ST_ACCUM) && !clear;
   assign beat       = prod_valid && prod_ready;

   sat_adder #(
      .ACC_W    (ACC_W),
      .DATA_W   (DATA_W),
      .SATURATE (SATURATE)
   ) u_add (
      .a   (sum_q),
      .b   (prod_data),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACCUM;
         sum_q     <= '0;
         acc_data  <= '0;
         term_cnt  <= '0;
         acc_valid <= 1'b0;
         acc_ovf   <= 1'b0;
      end else if (clear) begin
         // Any held result is dropped, even if acc_ready is high this cycle.
         state     <= ST_ACCUM;
         sum_q     <= '0;
         term_cnt  <= '0;
         acc_valid <= 1'b0;
         acc_ovf   <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (beat) begin
                  sum_q    <= add_sum;
                  term_cnt <= term_cnt + 1'b1;
                  if (add_ovf) begin
                     acc_ovf <= 1'b1;
                  end
                  if (term_cnt == LAST) begin
                     state     <= ST_DONE;
                     acc_data  <= add_sum;
                     acc_valid <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (acc_valid && acc_ready) begin
                  state     <= ST_ACCUM;
                  sum_q     <= '0;
                  term_cnt  <= '0;
                  acc_valid <= 1'b0;
                  acc_ovf   <= 1'b0;
               end
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator
module tb_product_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Shared-stimulus group: three TERMS=4 instances differing in width/saturation.
   logic       rst = 1'b1, clear = 1'b0, pv = 1'b0, ar = 1'b0;
   logic [3:0] pd = '0;
   logic       pr_a, pr_s, pr_w, av_a, av_s, av_w, ao_a, ao_s, ao_w;
   logic [7:0] ad_a;
   logic [4:0] ad_s, ad_w;
   logic [2:0] tc_a, tc_s, tc_w;

   // TERMS=16 instance for the multiplier link test.
   logic       pv16 = 1'b0, ar16 = 1'b0;
   logic [3:0] pd16 = '0;
   logic       pr16, av16, ao16;
   logic [7:0] ad16;
   logic [4:0] tc16;

   // TERMS=1 instance.
   logic       pv1 = 1'b0, ar1 = 1'b0;
   logic [3:0] pd1 = '0;
   logic       pr1, av1, ao1;
   logic [7:0] ad1;
   logic [0:0] tc1;

   product_accumulator #(.DATA_W(4), .ACC_W(8), .TERMS(4), .SATURATE(1)) dut_a (
      .clk(clk), .rst(rst), .clear(clear), .prod_data(pd), .prod_valid(pv), .prod_ready(pr_a),
      .acc_data(ad_a), .acc_valid(av_a), .acc_ready(ar), .acc_ovf(ao_a), .term_cnt(tc_a));
   product_accumulator #(.DATA_W(4), .ACC_W(5), .TERMS(4), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .clear(clear), .prod_data(pd), .prod_valid(pv), .prod_ready(pr_s),
      .acc_data(ad_s), .acc_valid(av_s), .acc_ready(ar), .acc_ovf(ao_s), .term_cnt(tc_s));
   product_accumulator #(.DATA_W(4), .ACC_W(5), .TERMS(4), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .clear(clear), .prod_data(pd), .prod_valid(pv), .prod_ready(pr_w),
      .acc_data(ad_w), .acc_valid(av_w), .acc_ready(ar), .acc_ovf(ao_w), .term_cnt(tc_w));
   product_accumulator #(.DATA_W(4), .ACC_W(8), .TERMS(16), .SATURATE(1)) dut16 (
      .clk(clk), .rst(rst), .clear(1'b0), .prod_data(pd16), .prod_valid(pv16), .prod_ready(pr16),
      .acc_data(ad16), .acc_valid(av16), .acc_ready(ar16), .acc_ovf(ao16), .term_cnt(tc16));
   product_accumulator #(.DATA_W(4), .ACC_W(8), .TERMS(1), .SATURATE(1)) dut1 (
      .clk(clk), .rst(rst), .clear(1'b0), .prod_data(pd1), .prod_valid(pv1), .prod_ready(pr1),
      .acc_data(ad1), .acc_valid(av1), .acc_ready(ar1), .acc_ovf(ao1), .term_cnt(tc1));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model for the shared group: index 0 = ACC_W 8 sat, 1 = ACC_W 5 sat, 2 = ACC_W 5 wrap.
   localparam int TERMS = 4;
   int  m_w[3]   = '{8, 5, 5};
   bit  m_sat[3] = '{1'b1, 1'b1, 1'b0};
   int  m_sum[3], m_data[3];
   bit  m_ovf[3];
   bit  m_pend;
   int  m_cnt;

   function automatic int g_pr(input int k);
      return (k == 0) ? int'(pr_a) : (k == 1) ? int'(pr_s) : int'(pr_w);
   endfunction
   function automatic int g_av(input int k);
      return (k == 0) ? int'(av_a) : (k == 1) ? int'(av_s) : int'(av_w);
   endfunction
   function automatic int g_ao(input int k);
      return (k == 0) ? int'(ao_a) : (k == 1) ? int'(ao_s) : int'(ao_w);
   endfunction
   function automatic int g_ad(input int k);
      return (k == 0) ? int'(ad_a) : (k == 1) ? int'(ad_s) : int'(ad_w);
   endfunction
   function automatic int g_tc(input int k);
      return (k == 0) ? int'(tc_a) : (k == 1) ? int'(tc_s) : int'(tc_w);
   endfunction

   task automatic model_restart();
      m_pend = 1'b0;
      m_cnt  = 0;
      for (int k = 0; k < 3; k++) begin
         m_sum[k] = 0;
         m_ovf[k] = 1'b0;
      end
   endtask

   // Called at a negedge; applies one cycle of stimulus and checks against the model.
   task automatic drive_cycle(input bit v, input int d, input bit r, input bit c);
      int t, lim;
      pv = v; pd = 4'(d); ar = r; clear = c;
      #1;
      for (int k = 0; k < 3; k++) chk("prod_ready", g_pr(k), int'(!m_pend && !c));
      @(posedge clk);
      if (c) begin
         model_restart();
      end else if (m_pend) begin
         if (r) model_restart();
      end else if (v) begin
         for (int k = 0; k < 3; k++) begin
            lim = (1 << m_w[k]) - 1;
            t   = m_sum[k] + d;
            if (t > lim) begin
               m_ovf[k] = 1'b1;
               t = m_sat[k] ? lim : t - (lim + 1);
            end
            m_sum[k] = t;
         end
         m_cnt++;
         if (m_cnt == TERMS) begin
            m_pend = 1'b1;
            for (int k = 0; k < 3; k++) m_data[k] = m_sum[k];
         end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("acc_valid", g_av(k), int'(m_pend));
         chk("term_cnt", g_tc(k), m_cnt);
         if (m_pend) begin
            chk("acc_data", g_ad(k), m_data[k]);
            chk("acc_ovf", g_ao(k), int'(m_ovf[k]));
         end
      end
      @(negedge clk);
      pv = 1'b0; ar = 1'b0; clear = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; pv = 1'b0; ar = 1'b0; clear = 1'b0;
      @(posedge clk);
      #1;
      model_restart();
      for (int k = 0; k < 3; k++) begin
         m_data[k] = 0;
         chk("rst acc_valid", g_av(k), 0);
         chk("rst acc_data", g_ad(k), 0);
         chk("rst acc_ovf", g_ao(k), 0);
         chk("rst term_cnt", g_tc(k), 0);
         chk("rst prod_ready", g_pr(k), 1);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      int b[4];
      int ea, es, ew;
      int os, ow;
   } vec_t;
   vec_t vq[$];

   task automatic add_vec(input int b0, b1, b2, b3, ea, es, ew, os, ow);
      vec_t v;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
      v.ea = ea; v.es = es; v.ew = ew; v.os = os; v.ow = ow;
      vq.push_back(v);
   endtask

   initial begin
      add_vec( 9,  6,  4,  1, 20, 20, 20, 0, 0);
      add_vec(15, 15, 15, 15, 60, 31, 28, 1, 1);
      add_vec( 0,  0,  0,  0,  0,  0,  0, 0, 0);
      add_vec( 8,  8,  8,  8, 32, 31,  0, 1, 1);
      add_vec( 1,  2,  3,  4, 10, 10, 10, 0, 0);
      add_vec(12,  9,  6,  4, 31, 31, 31, 0, 0);

      @(negedge clk);
      do_reset();
      chk("rst av16", int'(av16), 0);
      chk("rst tc16", int'(tc16), 0);
      chk("rst av1", int'(av1), 0);

      // Table vectors, back-to-back beats then a handshake.
      foreach (vq[i]) begin
         for (int j = 0; j < 4; j++) drive_cycle(1'b1, vq[i].b[j], 1'b0, 1'b0);
         chk("vec data a", int'(ad_a), vq[i].ea);
         chk("vec data s", int'(ad_s), vq[i].es);
         chk("vec data w", int'(ad_w), vq[i].ew);
         chk("vec ovf a", int'(ao_a), 0);
         chk("vec ovf s", int'(ao_s), vq[i].os);
         chk("vec ovf w", int'(ao_w), vq[i].ow);
         drive_cycle(1'b0, 0, 1'b1, 1'b0);
      end

      // Backpressure: result held, no beats taken, then handshake and next beat.
      for (int j = 0; j < 4; j++) drive_cycle(1'b1, 5, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) drive_cycle(1'b1, 7, 1'b0, 1'b0);
      chk("bp data", int'(ad_a), 20);
      chk("bp term_cnt", int'(tc_a), 4);
      drive_cycle(1'b1, 7, 1'b1, 1'b0);
      drive_cycle(1'b1, 7, 1'b0, 1'b0);
      chk("bp next beat", int'(tc_a), 1);
      do_reset();

      // Clear mid-run.
      drive_cycle(1'b1, 3, 1'b0, 1'b0);
      drive_cycle(1'b1, 3, 1'b0, 1'b0);
      drive_cycle(1'b1, 5, 1'b0, 1'b1);
      chk("clear term_cnt", int'(tc_a), 0);
      for (int j = 0; j < 4; j++) drive_cycle(1'b1, 2, 1'b0, 1'b0);
      chk("clear then data", int'(ad_a), 8);
      // Clear wins over a simultaneous result handshake.
      drive_cycle(1'b0, 0, 1'b1, 1'b1);
      chk("clear in done", int'(av_a), 0);

      // Reset mid-run and in DONE.
      drive_cycle(1'b1, 9, 1'b0, 1'b0);
      drive_cycle(1'b1, 9, 1'b0, 1'b0);
      do_reset();
      for (int j = 0; j < 4; j++) drive_cycle(1'b1, 11, 1'b0, 1'b0);
      do_reset();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         drive_cycle(($urandom % 4) != 0, int'($urandom % 16), ($urandom % 3) != 0,
                     ($urandom % 25) == 0);
      end

      // TERMS=16: all 16 products of the 2-bit x 2-bit multiplier.
      for (int i = 0; i < 16; i++) begin
         pv16 = 1'b1;
         pd16 = 4'((i >> 2) * (i % 4));
         #1;
         chk("link prod_ready", int'(pr16), 1);
         @(posedge clk);
         #1;
         chk("link valid", int'(av16), (i == 15) ? 1 : 0);
         @(negedge clk);
      end
      pv16 = 1'b0;
      chk("link data", int'(ad16), 36);
      chk("link ovf", int'(ao16), 0);
      chk("link term_cnt", int'(tc16), 16);
      #1;
      chk("link ready in done", int'(pr16), 0);
      ar16 = 1'b1;
      @(posedge clk);
      #1;
      chk("link handshake", int'(av16), 0);
      ar16 = 1'b0;
      @(negedge clk);

      // TERMS=1: each beat is a result.
      pv1 = 1'b1; pd1 = 4'd13;
      #1;
      chk("t1 ready", int'(pr1), 1);
      @(posedge clk);
      #1;
      chk("t1 valid", int'(av1), 1);
      chk("t1 data", int'(ad1), 13);
      chk("t1 term_cnt", int'(tc1), 1);
      @(negedge clk);
      pd1 = 4'd5;
      #1;
      chk("t1 ready done", int'(pr1), 0);
      ar1 = 1'b1;
      @(posedge clk);
      #1;
      chk("t1 handshake", int'(av1), 0);
      @(negedge clk);
      ar1 = 1'b0;
      #1;
      chk("t1 ready again", int'(pr1), 1);
      @(posedge clk);
      #1;
      chk("t1 data2", int'(ad1), 5);
      chk("t1 ovf", int'(ao1), 0);
      @(negedge clk);
      pv1 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
